delay_tap_match_det: RTL and testbench

- Consumes the new-to-old tap history bus produced by the enabled delay-register line, one stage downstream of it.
- Compares the whole DEPTH-sample window against a programmable pattern under a bit mask.
- Emits a registered match pulse, holds a lock flag for a fixed time, and counts matches.
- Used for sync-word and framing detection on sampled data streams.

---
 rtl/delay_tap_match_det.sv | 125 ++++++++++++
 tb/tb_delay_tap_match_det.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/delay_tap_match_det.sv
// ============================================================================
// Module      : delay_tap_match_det
// Description : Masked pattern matcher over a delay-line tap window with
//               warm-up gating, hold/lock timing and a saturating hit counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_tap_match_det #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 3,
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = 16
) (
    input  logic                   CLK_I,
    input  logic                   RSTN_I,
    input  logic                   EN_I,
    input  logic [WIDTH*DEPTH-1:0] TAPS_I,
    input  logic [WIDTH*DEPTH-1:0] PAT_I,
    input  logic [WIDTH*DEPTH-1:0] MASK_I,
    input  logic                   ARM_I,
    input  logic                   ONESHOT_I,
    input  logic                   CLR_I,
    output logic                   MATCH_O,
    output logic                   LOCK_O,
    output logic [CNT_W-1:0]       MATCH_CNT_O,
    output logic [1:0]             STATE_O
);

    localparam int WARM_W = $clog2(DEPTH + 1);
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [WARM_W-1:0] WARM_MAX  = WARM_W'(DEPTH);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WARM_W-1:0]  warm_q,  warm_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               match_q, match_d;

    logic [WIDTH*DEPTH-1:0] w_diff;
    logic                   w_warm_ok;
    logic                   w_hit;

    // The strobe that completes warm-up is already comparing a full window,
    // so one short of DEPTH is enough once EN_I is also present.
    assign w_warm_ok = (warm_q >= WARM_LAST);
    assign w_diff    = (TAPS_I ^ PAT_I) & MASK_I;
    assign w_hit     = EN_I & w_warm_ok & ~(|w_diff);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        warm_d  = (EN_I && (warm_q != WARM_MAX)) ? warm_q + WARM_W'(1) : warm_q;

        if (CLR_I) begin
            state_d = ST_IDLE;
            hold_d  = '0;
            cnt_d   = '0;
            warm_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ARM_I) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_hit) begin
                        match_d = 1'b1;
                        state_d = ST_HOLD;
                        hold_d  = HOLD_INIT;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_q == '0) begin
                        state_d = ONESHOT_I ? ST_IDLE : ST_ARMED;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    assign MATCH_O     = match_q;
    assign LOCK_O      = (state_q == ST_HOLD);
    assign MATCH_CNT_O = cnt_q;
    assign STATE_O     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_delay_tap_match_det.sv
// ============================================================================
// Module      : tb_delay_tap_match_det
// Description : Directed vector table plus hand sequences for saturation and
//               asynchronous reset of delay_tap_match_det.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_tap_match_det;

    localparam logic [23:0] P  = 24'hAABBCC;
    localparam logic [23:0] F  = 24'hFFFFFF;
    localparam logic [23:0] T1 = 24'h0000AA;
    localparam logic [23:0] T2 = 24'h00AABB;
    localparam logic [23:0] TM = 24'hAA11CC;
    localparam logic [23:0] MK = 24'hFF00FF;

    logic        clk, rst_n, en, arm, oneshot, clr;
    logic [23:0] taps, pat, mask;
    logic        match, lock, match_s, lock_s;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
    logic [1:0]  state, state_s;

    int errors = 0;
    int checks = 0;

    delay_tap_match_det #(.WIDTH(8), .DEPTH(3), .HOLD_CYC(4), .CNT_W(16)) dut (
        .CLK_I(clk), .RSTN_I(rst_n), .EN_I(en), .TAPS_I(taps), .PAT_I(pat),
        .MASK_I(mask), .ARM_I(arm), .ONESHOT_I(oneshot), .CLR_I(clr),
        .MATCH_O(match), .LOCK_O(lock), .MATCH_CNT_O(cnt), .STATE_O(state)
    );

    delay_tap_match_det #(.WIDTH(8), .DEPTH(3), .HOLD_CYC(4), .CNT_W(4)) dut_s (
        .CLK_I(clk), .RSTN_I(rst_n), .EN_I(en), .TAPS_I(taps), .PAT_I(pat),
        .MASK_I(mask), .ARM_I(arm), .ONESHOT_I(oneshot), .CLR_I(clr),
        .MATCH_O(match_s), .LOCK_O(lock_s), .MATCH_CNT_O(cnt_s), .STATE_O(state_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en, arm, clr, os;
        logic [23:0] taps, pat, mask;
        logic        m, l;
        logic [1:0]  s;
        logic [15:0] c;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v_en, input logic v_arm, input logic v_clr,
                                input logic v_os, input logic [23:0] v_taps,
                                input logic [23:0] v_pat, input logic [23:0] v_mask,
                                input logic v_m, input logic v_l, input logic [1:0] v_s,
                                input logic [15:0] v_c);
        vec_t v;
        v.en = v_en; v.arm = v_arm; v.clr = v_clr; v.os = v_os;
        v.taps = v_taps; v.pat = v_pat; v.mask = v_mask;
        v.m = v_m; v.l = v_l; v.s = v_s; v.c = v_c;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int idx, input logic m, input logic l,
                              input logic [1:0] s, input logic [15:0] c);
        chk("match", idx, {31'd0, match}, {31'd0, m});
        chk("lock", idx, {31'd0, lock}, {31'd0, l});
        chk("state", idx, {30'd0, state}, {30'd0, s});
        chk("cnt", idx, {16'd0, cnt}, {16'd0, c});
        chk("cnt4", idx, {28'd0, cnt_s}, {28'd0, c[3:0]});
    endtask

    int pulses;

    initial begin
        // warm-up gate: full window hits one clock after the third strobe
        add(0,1,0,0, 24'h0, P, F, 0,0,1,0);
        add(1,0,0,0, T1, P, F,  0,0,1,0);
        add(1,0,0,0, T2, P, F,  0,0,1,0);
        add(1,0,0,0, P,  P, F,  1,1,2,1);
        for (int k = 0; k < 3; k++) add(0,0,0,0, P, P, F, 0,1,2,1);
        add(0,0,0,0, P, P, F, 0,0,1,1);
        // continuous hits: one pulse every HOLD_CYC+1 clocks
        add(1,0,0,0, P, P, F, 1,1,2,2);
        for (int k = 0; k < 3; k++) add(1,0,0,0, P, P, F, 0,1,2,2);
        add(1,0,0,0, P, P, F, 0,0,1,2);
        add(1,0,0,0, P, P, F, 1,1,2,3);
        for (int k = 0; k < 3; k++) add(0,0,0,0, P, P, F, 0,1,2,3);
        add(0,0,0,0, P, P, F, 0,0,1,3);
        // clear, then a pattern matching the first strobe must wait for warm-up
        add(0,0,1,0, 24'h0, P, F, 0,0,0,0);
        add(0,1,0,0, 24'h0, T1, F, 0,0,1,0);
        add(1,0,0,0, T1, T1, F, 0,0,1,0);
        add(1,0,0,0, T2, T1, F, 0,0,1,0);
        add(1,0,0,0, P,  T1, F, 0,0,1,0);
        add(1,0,0,0, T1, T1, F, 1,1,2,1);
        for (int k = 0; k < 3; k++) add(0,0,0,0, T1, T1, F, 0,1,2,1);
        add(0,0,0,0, T1, T1, F, 0,0,1,1);
        // masked compare with oneshot
        add(1,0,0,1, TM, P, MK, 1,1,2,2);
        for (int k = 0; k < 3; k++) add(1,0,0,1, TM, P, MK, 0,1,2,2);
        add(1,0,0,1, TM, P, MK, 0,0,0,2);
        add(1,0,0,1, TM, P, MK, 0,0,0,2);
        add(1,1,0,1, TM, P, MK, 0,0,1,2);
        add(1,0,0,1, TM, P, MK, 1,1,2,3);
        for (int k = 0; k < 3; k++) add(0,0,0,1, TM, P, MK, 0,1,2,3);
        add(0,0,0,0, TM, P, MK, 0,0,1,3);
        // EN_I gating
        add(0,0,0,0, P, P, F, 0,0,1,3);
        add(0,0,0,0, P, P, F, 0,0,1,3);
        add(1,0,0,0, P, P, F, 1,1,2,4);
        for (int k = 0; k < 3; k++) add(0,0,0,0, P, P, F, 0,1,2,4);
        add(0,0,0,0, P, P, F, 0,0,1,4);
        // clear beats arm and hit; warm-up restarts
        add(1,1,1,0, P, P, F, 0,0,0,0);
        add(0,1,0,0, P, P, F, 0,0,1,0);
        add(1,0,0,0, P, P, F, 0,0,1,0);
        add(1,0,0,0, P, P, F, 0,0,1,0);
        add(1,0,0,0, P, P, F, 1,1,2,1);
        add(0,0,0,0, P, P, F, 0,1,2,1);

        rst_n = 1'b0; en = 0; arm = 0; oneshot = 0; clr = 0;
        taps = '0; pat = P; mask = F;
        repeat (2) @(posedge clk);
        #3;
        check_outs(-1, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; arm = vecs[i].arm; clr = vecs[i].clr;
            oneshot = vecs[i].os; taps = vecs[i].taps;
            pat = vecs[i].pat; mask = vecs[i].mask;
            tick();
            check_outs(i, vecs[i].m, vecs[i].l, vecs[i].s, vecs[i].c);
        end

        // saturation: 17 hits on continuous matching strobes
        en = 0; arm = 0; clr = 1; oneshot = 0; taps = P; pat = P; mask = F;
        tick();
        clr = 0; arm = 1;
        tick();
        arm = 0; en = 1;
        pulses = 0;
        for (int k = 0; k < 85; k++) begin
            tick();
            if (match) pulses++;
        end
        chk("sat_pulses", 100, pulses, 17);
        chk("sat_cnt16", 101, {16'd0, cnt}, 32'd17);
        chk("sat_cnt4", 102, {28'd0, cnt_s}, 32'hF);
        chk("sat_lock", 103, {31'd0, lock}, 32'd1);
        chk("sat_state", 104, {30'd0, state}, 32'd2);

        // asynchronous reset mid-HOLD
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lock", 110, {31'd0, lock}, 32'd0);
        chk("arst_cnt16", 111, {16'd0, cnt}, 32'd0);
        chk("arst_cnt4", 112, {28'd0, cnt_s}, 32'd0);
        chk("arst_state", 113, {30'd0, state}, 32'd0);
        chk("arst_match", 114, {31'd0, match}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_state", 120 + k, {30'd0, state}, 32'd0);
            chk("post_rst_match", 120 + k, {31'd0, match}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
